// File: rtl/instruction_fetch_controller.sv
// instruction_fetch_controller
//   Drives the PC of a combinational, same-cycle instruction memory, captures the
//   returned word into an output register and hands it to decode over valid/ready.
//   Program control is start/done; decode back-pressure stalls the fetch; a taken
//   branch redirects the PC and flushes the held instruction.
//
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   start           pulse, begins a program at RESET_PC (honoured in IDLE/DONE only)
//   PC              registered address to instruction memory
//   instruction     word read at PC, valid the same cycle
//   redirect_valid  branch/jump taken this cycle; redirect_pc is its target
//   if_valid/if_ready/if_instr/if_pc  fetch -> decode handshake
//   busy, done      decoded from state (FETCH|DRAIN, DONE)
//
// Optional build macro IFC_PERF_CNT_EN adds fetch_count / stall_count (16-bit,
// saturating, cleared on reset and on an honoured start).
module instruction_fetch_controller #(
  parameter int ADDR_W    = 5,
  parameter int INSTR_W   = 32,
  parameter int RESET_PC  = 0,
  parameter int LAST_ADDR = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic [ADDR_W-1:0]  PC,
  input  logic [INSTR_W-1:0] instruction,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               if_valid,
  input  logic               if_ready,
  output logic [INSTR_W-1:0] if_instr,
  output logic [ADDR_W-1:0]  if_pc,
  output logic               busy,
  output logic               done
`ifdef IFC_PERF_CNT_EN
  ,
  output logic [15:0]        fetch_count,
  output logic [15:0]        stall_count
`endif
);

  localparam logic [ADDR_W-1:0] RST_PC = ADDR_W'(RESET_PC);
  localparam logic [ADDR_W-1:0] LAST   = ADDR_W'(LAST_ADDR);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_DONE} state_t;

  typedef struct packed {
    logic               vld;
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc;
  } ifreg_t;

  state_t state, state_nxt;
  ifreg_t ifr;

  logic active;    // FETCH or DRAIN
  logic go;        // honoured start
  logic redir;     // honoured redirect
  logic redir_ok;  // target inside the program
  logic xfer;      // decode takes the held word this cycle
  logic load;      // capture a new word this cycle

  assign active   = (state == S_FETCH) || (state == S_DRAIN);
  assign go       = start && !active;
  assign redir    = redirect_valid && active;
  assign redir_ok = (redirect_pc <= LAST);
  assign xfer     = ifr.vld && if_ready;
  // Redirect wins over a load; a transfer in the same cycle is still accepted.
  assign load     = (state == S_FETCH) && (!ifr.vld || if_ready) && !redir;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE: if (go) state_nxt = S_FETCH;
      S_FETCH: begin
        if (redir)                   state_nxt = redir_ok ? S_FETCH : S_DONE;
        else if (load && PC == LAST) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (redir)     state_nxt = redir_ok ? S_FETCH : S_DONE;
        else if (xfer) state_nxt = S_DONE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    busy = active;
    done = (state == S_DONE);
  end

  // PC and fetch output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      PC  <= RST_PC;
      ifr <= '0;
    end else if (go) begin
      PC <= RST_PC;
    end else if (redir) begin
      ifr.vld <= 1'b0;
      if (redir_ok) PC <= redirect_pc;   // out-of-range target leaves PC where it is
    end else if (load) begin
      ifr.vld   <= 1'b1;
      ifr.instr <= instruction;
      ifr.pc    <= PC;
      if (PC != LAST) PC <= PC + ADDR_W'(1);   // PC parks on LAST, never wraps
    end else if (state == S_DRAIN && xfer) begin
      ifr.vld <= 1'b0;
    end
  end

  assign if_valid = ifr.vld;
  assign if_instr = ifr.instr;
  assign if_pc    = ifr.pc;

`ifdef IFC_PERF_CNT_EN
  // An honoured start only happens with if_valid low, so clearing never
  // competes with a count in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_count <= '0;
      stall_count <= '0;
    end else if (go) begin
      fetch_count <= '0;
      stall_count <= '0;
    end else begin
      if (xfer && fetch_count != 16'hFFFF)
        fetch_count <= fetch_count + 16'd1;
      if (ifr.vld && !if_ready && stall_count != 16'hFFFF)
        stall_count <= stall_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instruction_fetch_controller.sv
module tb_instruction_fetch_controller;

  localparam int ADDR_W = 5, INSTR_W = 32, RESET_PC = 0, LAST_ADDR = 10;
  localparam int M_IDLE = 0, M_RUN = 1, M_DONE = 2;

  logic               clk = 1'b0;
  logic               rst_n = 1'b1;
  logic               start = 1'b0;
  logic [ADDR_W-1:0]  PC;
  logic [INSTR_W-1:0] instruction;
  logic               redirect_valid = 1'b0;
  logic [ADDR_W-1:0]  redirect_pc = '0;
  logic               if_valid;
  logic               if_ready = 1'b0;
  logic [INSTR_W-1:0] if_instr;
  logic [ADDR_W-1:0]  if_pc;
  logic               busy, done;
`ifdef IFC_PERF_CNT_EN
  logic [15:0]        fetch_count, stall_count;
`endif

  int total = 0;
  int bad   = 0;
  int acc_q[$];   // if_pc of every word decode accepted

  instruction_fetch_controller #(
    .ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .RESET_PC(RESET_PC), .LAST_ADDR(LAST_ADDR)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .PC(PC), .instruction(instruction),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc),
    .busy(busy), .done(done)
`ifdef IFC_PERF_CNT_EN
    , .fetch_count(fetch_count), .stall_count(stall_count)
`endif
  );

  // Instruction memory: each word is its own address.
  function automatic logic [31:0] mem(input int a);
    return 32'(a);
  endfunction
  assign instruction = mem(int'(PC));

  initial forever #5 clk = ~clk;

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Program view: mode (idle/running/finished), the address the PC points at,
  // the word held for decode, and whether the last address has been issued.
  typedef struct packed {
    int mode; int npc; bit hv; int hi; int hp; bit exh; int fc; int sc;
  } model_t;

  model_t m;

  function automatic model_t mstep(input model_t c, input bit s, input bit rv,
                                   input int rpc, input bit rdy);
    model_t n = c;
    bit took = c.hv && rdy;
    if (took && n.fc < 65535) n.fc++;
    if (c.hv && !rdy && n.sc < 65535) n.sc++;
    if (c.mode != M_RUN) begin
      if (s) begin
        n.mode = M_RUN; n.npc = RESET_PC; n.exh = 0; n.fc = 0; n.sc = 0;
      end
    end else if (rv) begin
      n.hv = 0;
      if (rpc <= LAST_ADDR) begin n.npc = rpc; n.exh = 0; end
      else n.mode = M_DONE;
    end else if (!c.exh) begin
      if (!c.hv || rdy) begin
        n.hv = 1; n.hi = int'(mem(c.npc)); n.hp = c.npc;
        if (c.npc == LAST_ADDR) n.exh = 1; else n.npc = c.npc + 1;
      end
    end else if (took) begin
      n.hv = 0; n.mode = M_DONE;
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= '{mode: M_IDLE, npc: RESET_PC, hv: 0, hi: 0, hp: 0, exh: 0, fc: 0, sc: 0};
    else        m <= mstep(m, start, redirect_valid, int'(redirect_pc), if_ready);
  end

  // Compare process: outputs are settled mid-cycle, inputs were driven at posedge+1.
  always @(negedge clk) begin
    chk("PC",       PC,       m.npc);
    chk("if_valid", if_valid, m.hv);
    chk("if_instr", if_instr, m.hi);
    chk("if_pc",    if_pc,    m.hp);
    chk("busy",     busy,     m.mode == M_RUN);
    chk("done",     done,     m.mode == M_DONE);
`ifdef IFC_PERF_CNT_EN
    chk("fetch_count", fetch_count, m.fc);
    chk("stall_count", stall_count, m.sc);
`endif
    if (if_valid && if_ready) acc_q.push_back(int'(if_pc));
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic pulse_start();
    start = 1'b1; step(); start = 1'b0;
  endtask

  task automatic wait_pc(input int p, input string nm);
    int n = 0;
    while (!(if_valid && int'(if_pc) == p) && n < 50) begin step(); n++; end
    chk(nm, (if_valid && int'(if_pc) == p), 1);
  endtask

  task automatic wait_done(input string nm);
    int n = 0;
    while (!done && n < 60) begin step(); n++; end
    chk(nm, done, 1);
    chk({nm, "_busy"}, busy, 0);
  endtask

  task automatic chk_acc(input string nm, input int exp[$]);
    chk({nm, "_count"}, acc_q.size(), exp.size());
    foreach (exp[i])
      if (i < acc_q.size()) chk(nm, acc_q[i], exp[i]);
  endtask

  initial begin
    int straight[$];
    int redir_seq[$];
    for (int i = 0; i <= LAST_ADDR; i++) straight.push_back(i);
    redir_seq = '{0, 1, 2, 8, 9, 10};

    // Reset state
    rst_n = 1'b0;
    repeat (3) step();
    chk("rst_PC", PC, 0);
    chk("rst_if_valid", if_valid, 0);
    chk("rst_if_instr", if_instr, 0);
    chk("rst_if_pc", if_pc, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    rst_n = 1'b1;
    step();

    // 1: straight run
    if_ready = 1'b1;
    acc_q.delete();
    pulse_start();
    wait_done("s1_done");
    chk_acc("s1_pc", straight);

    // 3: redirect to 8 while if_pc=2
    acc_q.delete();
    pulse_start();
    wait_pc(2, "s3_reach2");
    redirect_valid = 1'b1; redirect_pc = 5'd8;
    step();
    redirect_valid = 1'b0;
    chk("s3_flush", if_valid, 0);
    chk("s3_pc", PC, 8);
    step();
    chk("s3_if_pc8", if_pc, 8);
    wait_done("s3_done");
    chk_acc("s3_pc_seq", redir_seq);

    // 4: out-of-range target
    pulse_start();
    wait_pc(3, "s4_reach3");
    redirect_valid = 1'b1; redirect_pc = 5'd20;
    step();
    redirect_valid = 1'b0;
    chk("s4_flush", if_valid, 0);
    chk("s4_done", done, 1);
    pulse_start();
    chk("s4_restart_pc", PC, 0);
    chk("s4_restart_busy", busy, 1);
    step();
    chk("s4_refetch0", if_pc, 0);
    chk("s4_refetch_v", if_valid, 1);
    wait_done("s4_end");

    // 2 / 6: stall for 3 cycles at if_pc=4
    pulse_start();
    wait_pc(4, "s2_reach4");
    if_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("s2_hold_instr", if_instr, 32'h4);
      chk("s2_hold_pc", PC, 5);
      chk("s2_hold_v", if_valid, 1);
    end
    if_ready = 1'b1;
    step();
    chk("s2_release", if_pc, 5);
    wait_done("s2_done");
`ifdef IFC_PERF_CNT_EN
    chk("s6_fetch", fetch_count, 11);
    chk("s6_stall", stall_count, 3);
`endif
    pulse_start();
`ifdef IFC_PERF_CNT_EN
    chk("s6_clr_fetch", fetch_count, 0);
    chk("s6_clr_stall", stall_count, 0);
`endif

    // 5: async reset mid-cycle at if_pc=6
    wait_pc(6, "s5_reach6");
    #2 rst_n = 1'b0;
    #1;
    chk("s5_PC", PC, 0);
    chk("s5_if_valid", if_valid, 0);
    chk("s5_if_instr", if_instr, 0);
    chk("s5_busy", busy, 0);
    start = 1'b1;
    step(); step();
    chk("s5_start_ignored", busy, 0);
    start = 1'b0; rst_n = 1'b1;
    step();
    chk("s5_idle_busy", busy, 0);
    chk("s5_idle_done", done, 0);

    // Randomized traffic against the model
    for (int c = 0; c < 4000; c++) begin
      rst_n          = ($urandom_range(0, 199) != 0);
      start          = ($urandom_range(0, 19) == 0);
      redirect_valid = ($urandom_range(0, 11) == 0);
      redirect_pc    = ADDR_W'($urandom_range(0, 31));
      if_ready       = ($urandom_range(0, 9) < 7);
      step();
    end
    rst_n = 1'b1; start = 1'b0; redirect_valid = 1'b0;
    step(); step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
